// File: rtl/host_ctrl.sv
// host_ctrl: sequences one accelerator run over a simple register-access
// request/response channel. It writes the run arguments, launches the run,
// polls the control register until the finish bit (bit 1) is set or the poll
// budget runs out, then reads back the cycle counter.
module host_ctrl #(
    parameter int          HOST_ADDR_BITS = 8,
    parameter int          HOST_DATA_BITS = 32,
    parameter logic [15:0] POLL_MAX       = 16'd1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [HOST_DATA_BITS-1:0] cfg_length,
    input  logic [HOST_DATA_BITS-1:0] cfg_a_addr,
    input  logic [HOST_DATA_BITS-1:0] cfg_b_addr,
    input  logic [HOST_DATA_BITS-1:0] cfg_c_addr,
    output logic                      host_req_valid,
    output logic                      host_req_opcode,
    output logic [HOST_ADDR_BITS-1:0] host_req_addr,
    output logic [HOST_DATA_BITS-1:0] host_req_value,
    input  logic                      host_req_deq,
    input  logic                      host_resp_valid,
    input  logic [HOST_DATA_BITS-1:0] host_resp_bits,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [HOST_DATA_BITS-1:0] cycles
);

    // Accelerator register map (byte addresses).
    localparam logic [HOST_ADDR_BITS-1:0] ADDR_CTRL   = HOST_ADDR_BITS'('h00);
    localparam logic [HOST_ADDR_BITS-1:0] ADDR_CYCLES = HOST_ADDR_BITS'('h04);
    localparam logic [HOST_ADDR_BITS-1:0] ADDR_LENGTH = HOST_ADDR_BITS'('h08);
    localparam logic [HOST_ADDR_BITS-1:0] ADDR_A      = HOST_ADDR_BITS'('h0c);
    localparam logic [HOST_ADDR_BITS-1:0] ADDR_B      = HOST_ADDR_BITS'('h10);
    localparam logic [HOST_ADDR_BITS-1:0] ADDR_C      = HOST_ADDR_BITS'('h14);

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    typedef enum logic [3:0] {
        IDLE,
        WR_LEN,
        WR_A,
        WR_B,
        WR_C,
        WR_LAUNCH,
        POLL_REQ,
        POLL_RESP,
        CYC_REQ,
        CYC_RESP,
        DONE
    } state_t;

    state_t                    state;
    logic [HOST_DATA_BITS-1:0] length_reg;
    logic [HOST_DATA_BITS-1:0] a_reg;
    logic [HOST_DATA_BITS-1:0] b_reg;
    logic [HOST_DATA_BITS-1:0] c_reg;
    logic [15:0]               poll_count;
    logic [15:0]               poll_count_next;

    assign poll_count_next = poll_count + 16'd1;

    // Run sequencer; every output is registered and set up on the transition
    // into the state that owns it, so a request is stable while it waits for deq.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            length_reg      <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            c_reg           <= '0;
            poll_count      <= '0;
            host_req_valid  <= 1'b0;
            host_req_opcode <= 1'b0;
            host_req_addr   <= '0;
            host_req_value  <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout         <= 1'b0;
            cycles          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        length_reg      <= cfg_length;
                        a_reg           <= cfg_a_addr;
                        b_reg           <= cfg_b_addr;
                        c_reg           <= cfg_c_addr;
                        poll_count      <= '0;
                        timeout         <= 1'b0;
                        cycles          <= '0;
                        busy            <= 1'b1;
                        host_req_valid  <= 1'b1;
                        host_req_opcode <= OP_WRITE;
                        host_req_addr   <= ADDR_LENGTH;
                        host_req_value  <= cfg_length;
                        state           <= WR_LEN;
                    end
                end
                WR_LEN: begin
                    if (host_req_deq) begin
                        host_req_addr  <= ADDR_A;
                        host_req_value <= a_reg;
                        state          <= WR_A;
                    end
                end
                WR_A: begin
                    if (host_req_deq) begin
                        host_req_addr  <= ADDR_B;
                        host_req_value <= b_reg;
                        state          <= WR_B;
                    end
                end
                WR_B: begin
                    if (host_req_deq) begin
                        host_req_addr  <= ADDR_C;
                        host_req_value <= c_reg;
                        state          <= WR_C;
                    end
                end
                WR_C: begin
                    if (host_req_deq) begin
                        host_req_addr  <= ADDR_CTRL;
                        host_req_value <= HOST_DATA_BITS'(1);
                        state          <= WR_LAUNCH;
                    end
                end
                WR_LAUNCH: begin
                    if (host_req_deq) begin
                        host_req_opcode <= OP_READ;
                        host_req_addr   <= ADDR_CTRL;
                        host_req_value  <= '0;
                        state           <= POLL_REQ;
                    end
                end
                POLL_REQ: begin
                    if (host_req_deq) begin
                        host_req_valid <= 1'b0;
                        state          <= POLL_RESP;
                    end
                end
                POLL_RESP: begin
                    if (host_resp_valid) begin
                        if (host_resp_bits[1]) begin
                            host_req_valid <= 1'b1;
                            host_req_addr  <= ADDR_CYCLES;
                            state          <= CYC_REQ;
                        end else begin
                            poll_count <= poll_count_next;
                            if (poll_count_next == POLL_MAX) begin
                                timeout <= 1'b1;
                                done    <= 1'b1;
                                state   <= DONE;
                            end else begin
                                host_req_valid <= 1'b1;
                                state          <= POLL_REQ;
                            end
                        end
                    end
                end
                CYC_REQ: begin
                    if (host_req_deq) begin
                        host_req_valid <= 1'b0;
                        state          <= CYC_RESP;
                    end
                end
                CYC_RESP: begin
                    if (host_resp_valid) begin
                        cycles <= host_resp_bits;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    host_req_valid <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_ctrl.sv
// tb_host_ctrl: randomized scoreboard bench for host_ctrl. The stimulus side
// predicts the full request list and the done result of each run from the
// run arguments and the planned poll outcome; a monitor pops and compares.
module tb_host_ctrl;

    localparam int          AW = 8;
    localparam int          DW = 32;
    localparam logic [15:0] PM = 16'd4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] cfg_length = '0;
    logic [DW-1:0] cfg_a_addr = '0;
    logic [DW-1:0] cfg_b_addr = '0;
    logic [DW-1:0] cfg_c_addr = '0;
    logic          host_req_valid;
    logic          host_req_opcode;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_value;
    logic          host_req_deq = 1'b0;
    logic          host_resp_valid = 1'b0;
    logic [DW-1:0] host_resp_bits = '0;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [DW-1:0] cycles;

    host_ctrl #(
        .HOST_ADDR_BITS(AW),
        .HOST_DATA_BITS(DW),
        .POLL_MAX      (PM)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .cfg_length     (cfg_length),
        .cfg_a_addr     (cfg_a_addr),
        .cfg_b_addr     (cfg_b_addr),
        .cfg_c_addr     (cfg_c_addr),
        .host_req_valid (host_req_valid),
        .host_req_opcode(host_req_opcode),
        .host_req_addr  (host_req_addr),
        .host_req_value (host_req_value),
        .host_req_deq   (host_req_deq),
        .host_resp_valid(host_resp_valid),
        .host_resp_bits (host_resp_bits),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .cycles         (cycles)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic          op;
        logic [AW-1:0] addr;
        logic [DW-1:0] value;
    } req_t;

    typedef struct {
        logic          to;
        logic [DW-1:0] cyc;
    } done_t;

    req_t  exp_req[$];
    done_t exp_done[$];

    // Responder controls, written by the stimulus process.
    int            stall_mode  = 0;   // 0 none, 1 four cycles on writes, 2 random 0..3
    int            spur_mode   = 0;   // 0 none, 1 every free cycle, 2 random
    int            delay_max   = 0;
    bit            hold_resp   = 1'b0;
    int            finish_at   = 0;   // poll number that reports finish, 0 = never
    logic [DW-1:0] counter_val = '0;
    int            resp_poll   = 0;

    // Responder state.
    bit            pending   = 1'b0;
    int            pend_delay = 0;
    logic [DW-1:0] pend_data = '0;
    int            stall_cnt = 0;
    int            stall_tgt = 0;
    bit            tgt_set   = 1'b0;

    // Responder: drives deq and read data 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            host_req_deq    = 1'b0;
            host_resp_valid = 1'b0;
            host_resp_bits  = $urandom;
            if (pending) begin
                if (!hold_resp) begin
                    if (pend_delay == 0) begin
                        host_resp_valid = 1'b1;
                        host_resp_bits  = pend_data;
                        pending         = 1'b0;
                    end else begin
                        pend_delay--;
                    end
                end
            end else begin
                if (spur_mode == 1 || (spur_mode == 2 && $urandom_range(0, 3) == 0)) begin
                    host_resp_valid = 1'b1;
                    host_resp_bits  = '1;
                end
                if (host_req_valid && reset) begin
                    if (!tgt_set) begin
                        if (stall_mode == 1 && host_req_opcode)
                            stall_tgt = 4;
                        else if (stall_mode == 2)
                            stall_tgt = int'($urandom_range(0, 3));
                        else
                            stall_tgt = 0;
                        stall_cnt = 0;
                        tgt_set   = 1'b1;
                    end
                    if (stall_cnt < stall_tgt) begin
                        stall_cnt++;
                    end else begin
                        host_req_deq = 1'b1;
                        tgt_set      = 1'b0;
                        if (!host_req_opcode) begin
                            pending    = 1'b1;
                            pend_delay = int'($urandom_range(0, delay_max));
                            if (host_req_addr == 8'h00) begin
                                resp_poll++;
                                pend_data = $urandom & ~32'h2;
                                if (resp_poll == finish_at)
                                    pend_data = pend_data | 32'h2;
                            end else begin
                                pend_data = counter_val;
                            end
                        end
                    end
                end
            end
        end
    end

    // Monitor: on the falling edge, checks accepted requests, stall stability and done results.
    initial begin
        logic          prev_stall;
        logic          prev_op;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_val;
        req_t          e;
        done_t         d;
        prev_stall = 1'b0;
        prev_op    = 1'b0;
        prev_addr  = '0;
        prev_val   = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    vectors++;
                    if (!(host_req_valid && host_req_opcode == prev_op &&
                          host_req_addr == prev_addr && host_req_value == prev_val)) begin
                        miscompares++;
                        $display("FAIL stall_stable: got v=%0b op=%0b addr=%0h val=%0h required v=1 op=%0b addr=%0h val=%0h",
                                 host_req_valid, host_req_opcode, host_req_addr, host_req_value,
                                 prev_op, prev_addr, prev_val);
                    end
                end
                if (host_req_valid) begin
                    vectors++;
                    if (!busy) begin
                        miscompares++;
                        $display("FAIL busy_with_req: got busy=0 required 1");
                    end
                end
                if (host_req_valid && host_req_deq) begin
                    vectors++;
                    if (exp_req.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_req: got op=%0b addr=%0h val=%0h required none",
                                 host_req_opcode, host_req_addr, host_req_value);
                    end else begin
                        e = exp_req.pop_front();
                        if (host_req_opcode !== e.op || host_req_addr !== e.addr || host_req_value !== e.value) begin
                            miscompares++;
                            $display("FAIL req: got op=%0b addr=%0h val=%0h required op=%0b addr=%0h val=%0h",
                                     host_req_opcode, host_req_addr, host_req_value, e.op, e.addr, e.value);
                        end else begin
                            $display("req  %s addr=%02h value=%08h", host_req_opcode ? "wr" : "rd",
                                     host_req_addr, host_req_value);
                        end
                    end
                end
                prev_stall = host_req_valid && !host_req_deq;
                prev_op    = host_req_opcode;
                prev_addr  = host_req_addr;
                prev_val   = host_req_value;
                if (done) begin
                    vectors++;
                    if (exp_done.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_done: got done=1 timeout=%0b cycles=%0h required no done",
                                 timeout, cycles);
                    end else begin
                        d = exp_done.pop_front();
                        if (timeout !== d.to || cycles !== d.cyc) begin
                            miscompares++;
                            $display("FAIL done_result: got timeout=%0b cycles=%0h required timeout=%0b cycles=%0h",
                                     timeout, cycles, d.to, d.cyc);
                        end else begin
                            $display("done timeout=%0b cycles=%08h", timeout, cycles);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic recover();
        reset = 1'b0;
        tick();
        tick();
        exp_req.delete();
        exp_done.delete();
        pending   = 1'b0;
        tgt_set   = 1'b0;
        hold_resp = 1'b0;
        reset     = 1'b1;
    endtask

    // Reference model: the request list and result implied by one run.
    task automatic predict(input logic [DW-1:0] len, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input int fin, input logic [DW-1:0] cnt,
                           output logic [DW-1:0] held);
        int    polls;
        bit    to;
        done_t d;
        to    = (fin == 0) || (fin > int'(PM));
        polls = to ? int'(PM) : fin;
        exp_req.push_back('{1'b1, 8'h08, len});
        exp_req.push_back('{1'b1, 8'h0c, a});
        exp_req.push_back('{1'b1, 8'h10, b});
        exp_req.push_back('{1'b1, 8'h14, c});
        exp_req.push_back('{1'b1, 8'h00, 32'h1});
        for (int i = 0; i < polls; i++)
            exp_req.push_back('{1'b0, 8'h00, 32'h0});
        if (!to)
            exp_req.push_back('{1'b0, 8'h04, 32'h0});
        held  = to ? '0 : cnt;
        d.to  = to;
        d.cyc = held;
        exp_done.push_back(d);
    endtask

    task automatic check_idle(input int n, input logic [DW-1:0] held);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_outputs", {61'd0, busy, host_req_valid, done}, 64'd0);
            chk("idle_cycles", {32'd0, cycles}, {32'd0, held});
        end
    endtask

    task automatic run(input logic [DW-1:0] len, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input int fin, input logic [DW-1:0] cnt,
                       input bit noise, input bit start_in_wrb, output logic [DW-1:0] held);
        bit seen;
        bit pulsed;
        predict(len, a, b, c, fin, cnt, held);
        finish_at   = fin;
        counter_val = cnt;
        resp_poll   = 0;
        cfg_length  = len;
        cfg_a_addr  = a;
        cfg_b_addr  = b;
        cfg_c_addr  = c;
        start       = 1'b1;
        tick();
        start      = 1'b0;
        cfg_length = $urandom;
        cfg_a_addr = $urandom;
        cfg_b_addr = $urandom;
        cfg_c_addr = $urandom;
        seen   = 1'b0;
        pulsed = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = 1'b0;
            if (start_in_wrb && !pulsed && host_req_valid && host_req_opcode && host_req_addr == 8'h10) begin
                cfg_length = ~len;
                cfg_a_addr = ~a;
                cfg_b_addr = ~b;
                cfg_c_addr = ~c;
                start      = 1'b1;
                pulsed     = 1'b1;
            end else if (noise && $urandom_range(0, 3) == 0) begin
                cfg_length = $urandom;
                cfg_a_addr = $urandom;
                start      = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        if (start_in_wrb)
            chk("start_in_wr_b_issued", {63'd0, pulsed}, 64'd1);
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL run_done: got no done within 600 cycles required done");
            recover();
            held = '0;
        end
        check_idle(2, held);
        chk("req_queue_drained", 64'(exp_req.size()), 64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] held;
        logic [DW-1:0] dummy;
        bit            got;

        // Reset values.
        reset = 1'b0;
        tick();
        tick();
        chk("reset_ctrl", {59'd0, host_req_valid, busy, done, timeout, host_req_opcode}, 64'd0);
        chk("reset_addr_value", {24'd0, host_req_addr, host_req_value}, 64'd0);
        chk("reset_cycles", {32'd0, cycles}, 64'd0);
        reset = 1'b1;

        // Spurious responses in IDLE.
        spur_mode = 1;
        check_idle(5, '0);
        spur_mode = 0;

        // Directed single run, ack in one cycle, finish on third poll.
        run(32'd16, 32'h100, 32'h200, 32'h300, 3, 32'h2A, 1'b0, 1'b0, held);
        chk("single_run_cycles", {32'd0, cycles}, 64'h2A);

        // Backpressure on writes with spurious responses while stalled.
        stall_mode = 1;
        spur_mode  = 1;
        run($urandom, $urandom, $urandom, $urandom, 2, $urandom | 32'h1, 1'b0, 1'b0, held);
        stall_mode = 0;
        spur_mode  = 0;

        // Finish never reported: timeout after PM polls.
        run(32'd7, 32'h11, 32'h22, 32'h33, 0, 32'hDEAD, 1'b0, 1'b0, held);
        chk("timeout_flag", {63'd0, timeout}, 64'd1);

        // Start pulsed during WR_B with different arguments.
        run(32'h55, 32'h1000, 32'h2000, 32'h3000, 1, 32'h77, 1'b0, 1'b1, held);

        // Reset while a poll read response is outstanding.
        hold_resp = 1'b1;
        predict(32'd1, 32'd2, 32'd3, 32'd4, 0, 32'h99, dummy);
        finish_at   = 0;
        counter_val = 32'h99;
        resp_poll   = 0;
        cfg_length  = 32'd1;
        cfg_a_addr  = 32'd2;
        cfg_b_addr  = 32'd3;
        cfg_c_addr  = 32'd4;
        start       = 1'b1;
        tick();
        start = 1'b0;
        got   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (pending) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("poll_read_outstanding", {63'd0, got}, 64'd1);
        tick();
        reset = 1'b0;
        tick();
        chk("midrun_reset_ctrl", {59'd0, host_req_valid, busy, done, timeout, host_req_opcode}, 64'd0);
        chk("midrun_reset_addr_value", {24'd0, host_req_addr, host_req_value}, 64'd0);
        chk("midrun_reset_cycles", {32'd0, cycles}, 64'd0);
        tick();
        exp_req.delete();
        exp_done.delete();
        reset      = 1'b1;
        pend_data  = '1;
        pend_delay = 0;
        hold_resp  = 1'b0;
        check_idle(10, '0);

        // Randomized runs with stalls, response delays, spurious responses and start noise.
        stall_mode = 2;
        spur_mode  = 2;
        delay_max  = 3;
        for (int r = 0; r < 30; r++) begin
            run($urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 6)), $urandom,
                1'b1, 1'b0, held);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/host_ctrl.md
HOST_CTRL -- requirements
Module: host_ctrl

Interface
REQ-001 Parameters SHALL be: HOST_ADDR_BITS, 8, host address width; HOST_DATA_BITS, 32, host data width; POLL_MAX, 1024, maximum status reads before timeout (16-bit).
REQ-002 The block SHALL use one clock and a synchronous active-low reset; all ports below are listed as name, direction, width, meaning.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous, active-low (0 = reset).
REQ-005 start  in  1  pulse requesting one accelerator run.
REQ-006 cfg_length, cfg_a_addr, cfg_b_addr, cfg_c_addr  in  HOST_DATA_BITS each  run arguments, sampled on accepted start.
REQ-007 host_req_valid  out  1  request present.
REQ-008 host_req_opcode  out  1  1 = write, 0 = read.
REQ-009 host_req_addr  out  HOST_ADDR_BITS  register byte address.
REQ-010 host_req_value  out  HOST_DATA_BITS  write data (0 on reads).
REQ-011 host_req_deq  in  1  responder accepts current request this cycle.
REQ-012 host_resp_valid  in  1  read data valid.
REQ-013 host_resp_bits  in  HOST_DATA_BITS  read data.
REQ-014 busy  out  1  run in progress.
REQ-015 done  out  1  one-cycle pulse at end of run.
REQ-016 timeout  out  1  valid with done; 1 = finish never observed.
REQ-017 cycles  out  HOST_DATA_BITS  cycle count read back; held until next accepted start.

Function
REQ-018 Request handshake: valid/opcode/addr/value SHALL stay constant from assertion until the cycle host_req_deq=1; the request completes in that cycle.
REQ-019 After a read is dequeued, the block SHALL deassert host_req_valid and wait any number of cycles for host_resp_valid, capturing host_resp_bits in that cycle.
REQ-020 host_resp_valid SHALL be ignored in every state other than a read-response wait.
REQ-021 FSM states: IDLE, WR_LEN, WR_A, WR_B, WR_C, WR_LAUNCH, POLL_REQ, POLL_RESP, CYC_REQ, CYC_RESP, DONE.
REQ-022 IDLE: start=1 SHALL latch the cfg_* inputs, clear poll count/timeout/cycles, and go to WR_LEN next cycle; start is ignored in all other states.
REQ-023 WR_LEN/WR_A/WR_B/WR_C SHALL write latched length/a/b/c to 0x08/0x0c/0x10/0x14, advancing in order on deq.
REQ-024 WR_LAUNCH SHALL write value 0x1 to 0x00, then go to POLL_REQ on deq.
REQ-025 POLL_REQ SHALL read 0x00, then go to POLL_RESP on deq.
REQ-026 POLL_RESP on response: bit1=1 -> CYC_REQ; else poll count+1, and if the new count == POLL_MAX set timeout and go to DONE, else go to POLL_REQ.
REQ-027 CYC_REQ SHALL read 0x04; CYC_RESP SHALL load cycles with response data, then go to DONE.
REQ-028 DONE SHALL assert done for exactly one cycle, then go to IDLE; busy=1 in every state except IDLE.
REQ-029 host_req_valid SHALL be 1 exactly in the WR_*, POLL_REQ and CYC_REQ states; a new request SHALL NOT issue while a read response is outstanding.
REQ-030 Minimum run latency with deq asserted immediately and response after 1 cycle: start -> done SHALL be 5 write + 2 cycles per poll + 2 cycle-read + 1 DONE + 1 start-latch cycles.
REQ-031 On timeout, cycles SHALL remain 0 and no 0x04 read SHALL issue.

Reset
REQ-032 While reset=0 at a clock edge, state -> IDLE; host_req_valid, busy, done, timeout = 0; cycles, poll count, latched cfg = 0; addr/value/opcode = 0.
REQ-033 Reset asserted mid-run, including with a read outstanding, SHALL abort immediately; any later host_resp_valid SHALL be ignored.

Verification
REQ-034 Single run: length=16, a=0x100, b=0x200, c=0x300; responder acks each request in 1 cycle; finish is set on the 3rd poll; counter=0x2A -> writes 0x08=16, 0x0c=0x100, 0x10=0x200, 0x14=0x300, 0x00=1, three 0x00 reads, one 0x04 read; done pulses once, timeout=0, cycles=0x2A.
REQ-035 Backpressure: hold deq=0 for 4 cycles on each write -> valid, addr and value stay stable throughout; order and values unchanged.
REQ-036 Timeout: POLL_MAX=4, finish never set -> exactly 4 reads of 0x00, no 0x04 read, done with timeout=1, cycles=0.
REQ-037 Start while busy: pulse start during WR_B with different cfg -> ignored; original values written; exactly one done.
REQ-038 Reset mid-poll: reset=0 while in POLL_RESP, then a response arrives after reset release -> outputs at reset values, state IDLE, response ignored, no done.
REQ-039 Spurious response: host_resp_valid=1 while in IDLE and WR_A -> no state or output change.
